axicb_pipe_arbiter: RTL
=======================

Name: axicb_pipe_arbiter

Overview:
- Shares one valid/ready pipeline stage chain among NB_REQ requesters, such as slave-side switch ports feeding a single master lane.
- Arbitration is round-robin. A grant is locked for a whole packet, from the first beat to the beat with last=1, so bursts are never interleaved.
- The output connects directly to a pipeline stage chain (NB_PIPELINE >= 0). The block tolerates any o_ready behaviour legal under valid/ready rules.

Parameters:
- NB_REQ, 4, number of requesters; legal range 2..16.
- DATA_BUS_W, 8, payload width per requester, in bits.
- USE_LAST, 1. Value 1: the grant is held until the i_last beat. Value 0: re-arbitration happens after every beat.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- srst  in  1  synchronous reset, active-high; same effect as aresetn.
- i_valid  in  NB_REQ  per-requester valid.
- i_ready  out  NB_REQ  per-requester ready.
- i_data  in  NB_REQ*DATA_BUS_W  payloads; requester k occupies bits [k*DATA_BUS_W +: DATA_BUS_W].
- i_last  in  NB_REQ  per-requester end-of-packet flag.
- o_valid  out  1  shared output valid.
- o_ready  in  1  shared output ready.
- o_data  out  DATA_BUS_W  muxed payload.
- o_last  out  1  muxed last flag.
- o_grant  out  NB_REQ  one-hot grant; all zeros when idle.

Behaviour:
- Reset (aresetn low, or srst high at a clock edge):
  - state=IDLE, grant=0, o_grant=0, o_valid=0, i_ready=0.
  - Priority pointer = NB_REQ-1, so requester 0 has highest priority first.
- State IDLE:
  - o_valid=0 and all i_ready=0.
  - If any i_valid is set, the sub-module selects the first requester with valid set, searching from pointer+1 upward with wrap-around.
  - The selection is registered into grant and the state moves to LOCKED.
  - The arbitration bubble is exactly one cycle.
- State LOCKED, with g the granted index:
  - o_valid = i_valid[g], o_data = i_data[g], o_last = i_last[g].
  - i_ready[g] = o_ready; all other i_ready are 0.
  - These paths are purely combinational, with zero added latency.
- Leaving LOCKED:
  - Condition: i_valid[g] & o_ready & (i_last[g] | ~USE_LAST).
  - Next state=IDLE, pointer=g, grant cleared.
  - In USE_LAST=0 mode the grant is cleared after every beat.
- Holding LOCKED: if i_valid[g] drops mid-packet, the state stays LOCKED and o_valid follows it to 0. Other requesters are not served.
- Fairness:
  - After g finishes, g has lowest priority.
  - Any continuously requesting requester waits at most NB_REQ-1 packets.
- Simultaneous events:
  - New requests arriving in the same cycle as a last handshake are ignored until the IDLE cycle.
  - A request that appears in IDLE is sampled at that edge.
- Data ordering: o_data and o_last are never taken from a non-granted requester. Beats within a packet keep their order.
- Reset mid-packet: the grant is dropped immediately and the block returns to IDLE. No beat is replayed; upstream must be reset as well.
- Invariant: o_grant is always one-hot or all zeros.

Decomposition:
- Package axicb_pkg: state enum (IDLE, LOCKED), plus a shared helper function for the one-hot to index conversion.
- Sub-module axicb_rr_arbiter, purely combinational:
  - Inputs: req[NB_REQ] and pointer.
  - Output: one-hot grant.
  - Implementation: mask-based double-priority encoder.
  - It is reused by the other crossbar switches.
- The top level owns the FSM, pointer/grant registers and the output mux.

Test Plan:
- Single requester: req1 sends a 3-beat packet 0xA1,0xA2,0xA3 (last on 3rd), o_ready=1.
  - Required: o_grant=4'b0010 one cycle after valid.
  - Required: 3 output beats in consecutive cycles, then IDLE.
- All four requesters continuously sending 1-beat packets, from reset.
  - Required: grant order 0,1,2,3,0, with one bubble between each beat.
- Lock check: req0 sends a 4-beat burst while req2 asserts valid throughout.
  - Required: req2 receives no i_ready until req0's last handshake.
  - Required: req2 is granted in the following arbitration.
- Backpressure: o_ready toggles 1,0,0,1 during a granted packet.
  - Required: o_data stays stable while o_valid=1 and o_ready=0.
  - Required: no beat is lost or duplicated, checked against a scoreboard.
- USE_LAST=0, req0 and req1 each sending 2-beat packets.
  - Required: beats interleave 0,1,0,1.
- Asynchronous reset mid-burst (beat 2 of 4).
  - Required: o_valid=0 and o_grant=0 immediately.
  - Required: after release, req0 has highest priority again.

Source files
------------

// File: rtl/axicb_pkg.sv
// Shared types and helpers for the crossbar switch arbitration logic.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package axicb_pkg;

    // Arbiter FSM: IDLE picks a new owner, LOCKED forwards the owner's beats.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Widest requester vector any switch instance supports.
    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned MAX_IDX_W = 4;

    // One-hot to binary index. Input must be one-hot or zero; OR-ing the
    // indices keeps this a flat OR tree instead of a priority chain.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(MAX_REQ); i++) begin
            if (oh[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axicb_rr_arbiter.sv
// Round-robin selector: one-hot grant of the first requester above ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is taken.
// Ports: req (request vector), ptr (index of the last served requester),
//        grant (one-hot selection, all zeros when req is zero).
module axicb_rr_arbiter #(
    parameter int NB_REQ = 4,
    parameter int IDX_W  = 2
)(
    input  logic [NB_REQ-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NB_REQ-1:0] grant
);

    logic [NB_REQ-1:0] mask;
    logic [NB_REQ-1:0] req_masked;
    logic [NB_REQ-1:0] gnt_masked;
    logic [NB_REQ-1:0] gnt_raw;

    // Double priority encoder: the masked search covers indices strictly
    // above ptr; if none request there, the unmasked search provides the
    // wrap-around back to index 0.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            mask[i] = (i > int'(ptr));
        end
        req_masked = req & mask;
        // x & -x isolates the lowest set bit.
        gnt_masked = req_masked & (~req_masked + NB_REQ'(1));
        gnt_raw    = req & (~req + NB_REQ'(1));
        grant      = (|req_masked) ? gnt_masked : gnt_raw;
    end

endmodule

// File: rtl/axicb_pipe_arbiter.sv
// Packet-locked round-robin mux sharing one valid/ready output among NB_REQ requesters.
// Latency: one-cycle arbitration bubble per packet, then zero-latency combinational forwarding.
// Backpressure: o_ready is routed only to the granted requester; all others see ready low.
// Ports: aclk/aresetn (async, active-low)/srst (sync, active-high);
//        i_valid/i_ready/i_data/i_last per requester (data packed k*DATA_BUS_W);
//        o_valid/o_ready/o_data/o_last shared output; o_grant one-hot owner or zero.
module axicb_pipe_arbiter
    import axicb_pkg::*;
#(
    parameter int NB_REQ     = 4,
    parameter int DATA_BUS_W = 8,
    parameter bit USE_LAST   = 1'b1
)(
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         srst,
    input  logic [NB_REQ-1:0]            i_valid,
    output logic [NB_REQ-1:0]            i_ready,
    input  logic [NB_REQ*DATA_BUS_W-1:0] i_data,
    input  logic [NB_REQ-1:0]            i_last,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [DATA_BUS_W-1:0]        o_data,
    output logic                         o_last,
    output logic [NB_REQ-1:0]            o_grant
);

    localparam int IDX_W = $clog2(NB_REQ);

    arb_state_t        state;
    logic [NB_REQ-1:0] grant;
    logic [NB_REQ-1:0] rr_grant;
    logic [IDX_W-1:0]  ptr;
    logic              leave;

    axicb_rr_arbiter #(
        .NB_REQ (NB_REQ),
        .IDX_W  (IDX_W)
    ) u_rr (
        .req   (i_valid),
        .ptr   (ptr),
        .grant (rr_grant)
    );

    // Output mux. grant is zero outside LOCKED, so the AND-OR structure
    // never lets a non-granted requester reach the output.
    always_comb begin
        o_valid = 1'b0;
        o_last  = 1'b0;
        o_data  = '0;
        i_ready = '0;
        if (state == LOCKED) begin
            o_valid = |(i_valid & grant);
            o_last  = |(i_last & grant);
            i_ready = grant & {NB_REQ{o_ready}};
            for (int k = 0; k < NB_REQ; k++) begin
                o_data = o_data | (i_data[k*DATA_BUS_W +: DATA_BUS_W] & {DATA_BUS_W{grant[k]}});
            end
        end
    end

    // Packet ends on the last-beat handshake, or on every beat without USE_LAST.
    assign leave = (state == LOCKED) && o_valid && o_ready && (o_last || !USE_LAST);

    assign o_grant = grant;

    // Pointer resets to NB_REQ-1 so requester 0 wins the first arbitration.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= IDX_W'(NB_REQ - 1);
        end else if (srst) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= IDX_W'(NB_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|i_valid) begin
                        grant <= rr_grant;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (leave) begin
                        // The finished owner becomes lowest priority next time.
                        ptr   <= IDX_W'(onehot_to_idx(MAX_REQ'(grant)));
                        grant <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule
